// File: rtl/sevseg_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment scanner with PWM brightness, blink and leading-zero blanking.
// Outputs are registered one clk behind the counters; there is no backpressure, the inputs are sampled once per frame.
module sevseg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 1024,
  parameter int BRIGHT_W   = 4,
  parameter int BLINK_W    = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    lz_suppress,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           pre;
  logic [BRIGHT_W-1:0]     phase;
  logic [IW-1:0]           idx;
  logic [BLINK_W-1:0]      blink_cnt;
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp, snap_blank, snap_blink;
  logic                    snap_lz;

  logic tick, slot_end, frame_end;
  assign tick      = (pre == PRE_MAX);
  assign slot_end  = tick & (&phase);
  assign frame_end = slot_end & (idx == IDX_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      pre         <= '0;
      phase       <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_blank  <= '0;
      snap_blink  <= '0;
      snap_lz     <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick)
        phase <= phase + 1'b1;
      if (slot_end)
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      // Inputs are frozen for the whole frame that is about to start.
      if (frame_end) begin
        blink_cnt   <= blink_cnt + 1'b1;
        snap_digits <= digits;
        snap_dp     <= dp_in;
        snap_blank  <= blank;
        snap_blink  <= blink_en;
        snap_lz     <= lz_suppress;
      end
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  // Leading-zero run walks down from the top digit; digit 0 always shows.
  logic [NUM_DIGITS-1:0] supp;
  logic                  zero_run;
  always_comb begin
    supp     = '0;
    zero_run = snap_lz;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (snap_digits[4*i +: 4] == 4'h0);
      supp[i]  = zero_run;
    end
  end

  logic [NUM_DIGITS-1:0] dark;
  assign dark = snap_blank | (snap_blink & {NUM_DIGITS{blink_cnt[BLINK_W-1]}}) | supp;

  logic [3:0]            cur_val;
  logic                  cur_dp, cur_dark, lit;
  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [NUM_DIGITS-1:0] an_d;
  always_comb begin
    cur_val  = 4'h0;
    cur_dp   = 1'b0;
    cur_dark = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_val  = snap_digits[4*i +: 4];
        cur_dp   = snap_dp[i];
        cur_dark = dark[i];
      end
    end
    lit   = (phase < brightness) & ~cur_dark;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    an_d  = '1;
    if (lit) begin
      seg_d = glyph(cur_val);
      dp_d  = ~cur_dp;
      for (int i = 0; i < NUM_DIGITS; i++)
        if (idx == IW'(i))
          an_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg        <= 7'h7F;
      dp         <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_d;
      dp         <= dp_d;
      an         <= an_d;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Directed and random stimulus against a cycle-count based display model (4 digits, tick every clk).
module tb_sevseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dp_in, blank, blink_en;
  logic        lz_suppress;
  logic [1:0]  brightness;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  sevseg_scan_ctrl #(.NUM_DIGITS(4), .TICK_DIV(1), .BRIGHT_W(2), .BLINK_W(2)) dut (
    .clk(clk), .reset(reset), .digits(digits), .dp_in(dp_in), .blank(blank),
    .blink_en(blink_en), .lz_suppress(lz_suppress), .brightness(brightness),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Clocks since reset release; slot = 4 clks, frame = 16 clks.
  int          cnt;
  logic [15:0] m_digits;
  logic [3:0]  m_dp, m_blank, m_blink;
  logic        m_lz;
  logic [6:0]  glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cnt=%0d: got %h expected %h", tag, cnt, got, exp);
    end
  endtask

  task automatic cycle();
    logic [6:0] e_seg;
    logic       e_dp, e_fd, is_dark, show_seg;
    logic [3:0] e_an, v;
    int         ph, ix, fr;
    e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fd = 1'b0; show_seg = 1'b1;
    if (reset) begin
      cnt = 0;
      m_digits = '0; m_dp = '0; m_blank = '0; m_blink = '0; m_lz = 1'b0;
    end else begin
      ph = cnt % 4;
      ix = (cnt / 4) % 4;
      fr = cnt / 16;
      v  = m_digits[ix*4 +: 4];
      is_dark = m_blank[ix] || (m_blink[ix] && (fr % 4) >= 2) ||
                (m_lz && ix > 0 && (m_digits >> (4*ix)) == 16'h0);
      if (!is_dark && ph < int'(brightness)) begin
        e_an[ix] = 1'b0;
        e_seg    = glyph[v];
        e_dp     = ~m_dp[ix];
      end else if (!is_dark) begin
        show_seg = 1'b0;
      end
      e_fd = (cnt % 16 == 15);
      if (e_fd) begin
        m_digits = digits; m_dp = dp_in; m_blank = blank; m_blink = blink_en; m_lz = lz_suppress;
      end
      cnt++;
    end
    @(posedge clk);
    #1;
    chk("an", 32'(an), 32'(e_an));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    if (show_seg) begin
      chk("seg", 32'(seg), 32'(e_seg));
      chk("dp", 32'(dp), 32'(e_dp));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset = 1'b1; digits = '0; dp_in = '0; blank = '0; blink_en = '0;
    lz_suppress = 1'b0; brightness = 2'd0; cnt = 0;
    m_digits = '0; m_dp = '0; m_blank = '0; m_blink = '0; m_lz = 1'b0;
    @(negedge clk);
    run(3);
    reset = 1'b0;

    // Basic scan of 1234 at brightness 3
    digits = 16'h1234; brightness = 2'd3;
    run(48);

    // Brightness 0 with everything enabled: anodes stay off, frame_done continues
    brightness = 2'd0; dp_in = 4'hF; blink_en = 4'hF; lz_suppress = 1'b1;
    run(48);
    dp_in = '0; blink_en = '0; brightness = 2'd3;

    // Leading-zero suppression
    digits = 16'h0050;
    run(32);
    digits = 16'h0000;
    run(32);
    lz_suppress = 1'b0;

    // Blink on digit 1, DP on digit 0, over two blink periods
    digits = 16'h4321; blink_en = 4'b0010; dp_in = 4'b0001;
    run(128);
    blink_en = '0; dp_in = '0;

    // Mid-frame digit change takes effect only at the next frame
    digits = 16'h1111;
    while (cnt % 16 != 0) cycle();
    run(16);
    run(5);
    digits = 16'h2222;
    run(27);

    // Reset in the middle of digit 2's slot
    digits = 16'h0300;
    while (!((cnt % 16) == 9 && cnt > 16)) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    run(20);

    // Random inputs, with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        for (int d = 0; d < 4; d++)
          digits[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        dp_in       = 4'($urandom);
        blank       = 4'($urandom) & 4'($urandom) & 4'($urandom);
        blink_en    = 4'($urandom) & 4'($urandom);
        lz_suppress = 1'($urandom);
        brightness  = 2'($urandom);
      end
      reset = ($urandom_range(0, 299) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
